// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, carry held in a flop.
// Operands in and result out over valid/ready handshakes; latency WIDTH cycles.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic cell_sum, cell_carry;

  assign cell_sum   = sh_a_q[0] ^ sh_b_q[0] ^ carry_q;
  assign cell_carry = (sh_a_q[0] & sh_b_q[0]) | (sh_a_q[0] & carry_q) | (sh_b_q[0] & carry_q);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    carry_d = carry_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          sh_a_d  = a;
          sh_b_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        sh_a_d  = sh_a_q >> 1;
        sh_b_d  = sh_b_q >> 1;
        // Sum enters at the MSB so after WIDTH shifts bit 0 lands in sum[0].
        sum_d             = sum_q >> 1;
        sum_d[WIDTH-1]    = cell_sum;
        carry_d = cell_carry;
        count_d = count_q + 1'b1;
        if (count_q == LastCnt) begin
          // carry_q is still the carry into the MSB at this point.
          cout_d  = cell_carry;
          ovf_d   = carry_q ^ cell_carry;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      carry_q <= 1'b0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      carry_q <= carry_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: WIDTH=8 and WIDTH=1 instances checked against
// an arithmetic model of A + B + cin with signed-range overflow.
module tb_serial_adder_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, out_valid, out_ready, cin, cout, overflow;
  logic [7:0] a, b, sum;

  logic w1_in_valid, w1_in_ready, w1_out_valid, w1_out_ready, w1_cin, w1_cout, w1_overflow;
  logic [0:0] w1_a, w1_b, w1_sum;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (w1_in_valid),
    .in_ready  (w1_in_ready),
    .a         (w1_a),
    .b         (w1_b),
    .cin       (w1_cin),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .sum       (w1_sum),
    .cout      (w1_cout),
    .overflow  (w1_overflow)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: unsigned sum mod 2^w, carry-out, and signed-range overflow.
  function automatic void model(input int w, input int unsigned x, input int unsigned y,
                                input int unsigned c, output int unsigned s,
                                output int unsigned co, output int unsigned ov);
    int unsigned t;
    int          sx, sy, sv;
    t  = x + y + c;
    s  = t % (32'd1 << w);
    co = t >> w;
    sx = int'(x);
    sy = int'(y);
    if (x >= (32'd1 << (w - 1))) sx = sx - (1 << w);
    if (y >= (32'd1 << (w - 1))) sy = sy - (1 << w);
    sv = sx + sy + int'(c);
    ov = ((sv > (1 << (w - 1)) - 1) || (sv < -(1 << (w - 1)))) ? 1 : 0;
  endfunction

  // Runs one 8-bit op; caller is #1 after a posedge with the DUT idle.
  task automatic op8(input int unsigned ta, input int unsigned tb_v, input int unsigned tc,
                     input int hold);
    int unsigned es, ec, eo;
    int          lat;
    model(8, ta, tb_v, tc, es, ec, eo);
    check("in_ready_idle", 32'(in_ready), 1);
    in_valid = 1'b1;
    a        = 8'(ta);
    b        = 8'(tb_v);
    cin      = 1'(tc);
    @(posedge clk); #1;
    // Garbage with in_valid still high must be ignored outside IDLE.
    a   = 8'($urandom);
    b   = 8'($urandom);
    cin = 1'($urandom);
    check("in_ready_run", 32'(in_ready), 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 8);
    check("sum", 32'(sum), es);
    check("cout", 32'(cout), ec);
    check("overflow", 32'(overflow), eo);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 1);
      check("hold_sum", 32'(sum), es);
      check("hold_cout", 32'(cout), ec);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("valid_drop", 32'(out_valid), 0);
    check("in_ready_back", 32'(in_ready), 1);
    check("sum_retained", 32'(sum), es);
  endtask

  task automatic op1(input int unsigned ta, input int unsigned tb_v, input int unsigned tc);
    int unsigned es, ec, eo;
    int          lat;
    model(1, ta, tb_v, tc, es, ec, eo);
    w1_in_valid = 1'b1;
    w1_a        = 1'(ta);
    w1_b        = 1'(tb_v);
    w1_cin      = 1'(tc);
    @(posedge clk); #1;
    w1_in_valid = 1'b0;
    lat = 0;
    while (!w1_out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    check("w1_latency", 32'(lat), 1);
    check("w1_sum", 32'(w1_sum), es);
    check("w1_cout", 32'(w1_cout), ec);
    check("w1_overflow", 32'(w1_overflow), eo);
    w1_out_ready = 1'b1;
    @(posedge clk); #1;
    w1_out_ready = 1'b0;
    check("w1_in_ready_back", 32'(w1_in_ready), 1);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    a            = '0;
    b            = '0;
    cin          = 1'b0;
    w1_in_valid  = 1'b0;
    w1_out_ready = 1'b0;
    w1_a         = '0;
    w1_b         = '0;
    w1_cin       = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_sum", 32'(sum), 0);
    check("rst_cout", 32'(cout), 0);
    check("rst_overflow", 32'(overflow), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    op8(32'h00, 32'h00, 0, 0);
    op8(32'hFF, 32'h01, 0, 0);
    op8(32'h7F, 32'h01, 0, 0);
    op8(32'h55, 32'hAA, 1, 5);

    // Abort mid-RUN: start an op, assert reset after three bits.
    in_valid = 1'b1;
    a        = 8'h0F;
    b        = 8'h01;
    cin      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 1);
    check("abort_out_valid", 32'(out_valid), 0);
    check("abort_sum", 32'(sum), 0);
    check("abort_cout", 32'(cout), 0);
    check("abort_overflow", 32'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    op8(32'h03, 32'h04, 0, 0);

    for (int i = 0; i < 30; i++) begin
      op8($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 1),
          int'($urandom_range(0, 3)));
    end

    for (int i = 0; i < 8; i++) begin
      op1(32'((i >> 2) & 1), 32'((i >> 1) & 1), 32'(i & 1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
